// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage ROM, redirect and F/D register bundle
interface fetch_stage_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jr_taken;
    logic [ADDR_W-1:0] jr_target;
    logic [31:0]       ins_out;
    logic [31:0]       pc_out;
    logic [31:0]       jump_out;
    logic              fd_valid;

    modport master (
        output imem_addr, ins_out, pc_out, jump_out, fd_valid,
        input  imem_data, stall, br_taken, br_target, jr_taken, jr_target
    );

    modport slave (
        input  imem_addr, ins_out, pc_out, jump_out, fd_valid,
        output imem_data, stall, br_taken, br_target, jr_taken, jr_target
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with F/D register; FETCH_PERF_EN adds perf counters
module fetch_stage #(
    parameter int          ADDR_W   = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clock,
    input  logic          aclr,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_bubbles
`endif
);

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_JAL = 5'b00011;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_jump;
    logic              redirect;

    assign pc_inc   = pc + 1'b1;
    assign is_jump  = (bus.imem_data[31:27] == OP_J) || (bus.imem_data[31:27] == OP_JAL);
    assign redirect = bus.jr_taken || bus.br_taken;

    // The ROM registers its address, so it is fed the next PC to line data up with pc.
    always_comb begin
        pc_next = pc_inc;
        if (aclr)
            pc_next = ADDR_W'(RESET_PC);
        else if (bus.jr_taken)
            pc_next = bus.jr_target;
        else if (bus.br_taken)
            pc_next = bus.br_target;
        else if (bus.stall)
            pc_next = pc;
        else if (is_jump)
            pc_next = bus.imem_data[ADDR_W-1:0];
    end

    assign bus.imem_addr = pc_next;

    always_ff @(posedge clock) begin
        pc <= pc_next;
        if (aclr || redirect) begin
            bus.ins_out  <= '0;
            bus.pc_out   <= '0;
            bus.jump_out <= '0;
            bus.fd_valid <= 1'b0;
        end else if (!bus.stall) begin
            bus.ins_out  <= bus.imem_data;
            bus.pc_out   <= {{(32-ADDR_W){1'b0}}, pc_inc};
            bus.jump_out <= {5'b0, bus.imem_data[26:0]};
            bus.fd_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (aclr) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else if (redirect || bus.stall) begin
            if (perf_bubbles != 32'hFFFF_FFFF)
                perf_bubbles <= perf_bubbles + 1'b1;
        end else begin
            if (perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 1'b1;
        end
    end
`endif

endmodule
